// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID-stage instruction info, branch resolution
// and the stall/flush/forward controls returned to the pipeline.
interface hazard_ctrl_if;
   // ID stage instruction description
   logic       id_valid;
   logic [3:0] id_rs1;
   logic [3:0] id_rs2;
   logic       id_rs1_used;
   logic       id_rs2_used;
   logic       id_WRegEn;
   logic       id_mem_to_reg;
   logic [3:0] id_WReg1;
   logic       id_multi;
   // EX stage branch resolution
   logic       br_taken;
   // Pipeline controls
   logic       pc_stall;
   logic       ifid_stall;
   logic       ifid_flush;
   logic       idex_bubble;
   logic       idex_hold;
   logic       exmem_bubble;
   logic [1:0] fwd_a_sel;
   logic [1:0] fwd_b_sel;
   logic       busy;

   // Pipeline side: describes the ID instruction, consumes controls
   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_WRegEn, id_mem_to_reg, id_WReg1, id_multi, br_taken,
      input  pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_hold,
             exmem_bubble, fwd_a_sel, fwd_b_sel, busy
   );

   // Hazard controller side
   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_WRegEn, id_mem_to_reg, id_WReg1, id_multi, br_taken,
      output pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_hold,
             exmem_bubble, fwd_a_sel, fwd_b_sel, busy
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 16-bit, 16-register core.
// A shadow scoreboard mirrors the destination info of EX, MEM and WB.
// From it and the ID instruction we derive stalls, bubbles, flushes and
// registered forwarding selects; multi-cycle EX ops are sequenced by a
// down-counter in the MC_BUSY state.
module hazard_ctrl #(
   parameter int MC_LAT   = 4,     // EX occupancy of a multi-cycle op (2..15)
   parameter bit ZERO_REG = 1'b1   // register 0 reads as zero, never forwarded
) (
   input  logic        CLK,
   input  logic        RST,
   hazard_ctrl_if.slave hz
);

   typedef enum logic [0:0] {
      ST_RUN     = 1'b0,
      ST_MC_BUSY = 1'b1
   } state_t;

   typedef struct packed {
      logic       valid;
      logic       wen;
      logic       load;
      logic [3:0] rd;
   } sb_entry_t;

   localparam sb_entry_t SB_EMPTY = 7'd0;
   localparam logic [3:0] CNT_LOAD = 4'(MC_LAT - 1);

   // True when entry e produces the register rs that the ID instruction reads.
   // allow_load=0 excludes loads (their data is not ready at the EX/MEM tap).
   function automatic logic f_match(input sb_entry_t e, input logic [3:0] rs,
                                    input logic used, input logic allow_load);
      logic zero_src;
      zero_src = ZERO_REG & (rs == 4'd0);
      f_match  = e.valid & e.wen & (e.rd == rs) & used & ~zero_src
                 & (allow_load | ~e.load);
   endfunction

   // Forward select for one operand; the nearest producing stage wins.
   function automatic logic [1:0] f_fwd_sel(input sb_entry_t ex_e,
                                            input sb_entry_t mem_e,
                                            input sb_entry_t wb_e,
                                            input logic [3:0] rs,
                                            input logic used);
      if (f_match(ex_e, rs, used, 1'b0)) begin
         f_fwd_sel = 2'b01;
      end else if (f_match(mem_e, rs, used, 1'b1)) begin
         f_fwd_sel = 2'b10;
      end else if (f_match(wb_e, rs, used, 1'b1)) begin
         // WB writes the register file before ID reads it
         f_fwd_sel = 2'b00;
      end else begin
         f_fwd_sel = 2'b00;
      end
   endfunction

   // Registered state
   state_t     r_state;
   logic [3:0] r_cnt;
   sb_entry_t  r_ex;
   sb_entry_t  r_mem;
   sb_entry_t  r_wb;
   logic [1:0] r_fwd_a;
   logic [1:0] r_fwd_b;

   // Combinational controls and next-state values
   sb_entry_t  w_id_entry;
   logic       w_load_use;
   logic [1:0] w_fwd_a;
   logic [1:0] w_fwd_b;
   logic       w_advance;
   logic       w_pc_stall;
   logic       w_ifid_stall;
   logic       w_ifid_flush;
   logic       w_idex_bubble;
   logic       w_idex_hold;
   logic       w_exmem_bubble;
   logic       w_busy;
   state_t     w_nxt_state;
   logic [3:0] w_nxt_cnt;
   sb_entry_t  w_nxt_ex;
   sb_entry_t  w_nxt_mem;
   sb_entry_t  w_nxt_wb;
   logic [1:0] w_nxt_fwd_a;
   logic [1:0] w_nxt_fwd_b;

   assign w_id_entry = {hz.id_valid, hz.id_WRegEn, hz.id_mem_to_reg, hz.id_WReg1};

   // A load in EX cannot feed the ID instruction until it reaches MEM
   assign w_load_use = hz.id_valid & r_ex.load &
                       (f_match(r_ex, hz.id_rs1, hz.id_rs1_used, 1'b1) |
                        f_match(r_ex, hz.id_rs2, hz.id_rs2_used, 1'b1));

   assign w_fwd_a = f_fwd_sel(r_ex, r_mem, r_wb, hz.id_rs1, hz.id_rs1_used);
   assign w_fwd_b = f_fwd_sel(r_ex, r_mem, r_wb, hz.id_rs2, hz.id_rs2_used);

   // Control decode and next-state for FSM, counter and scoreboard
   always_comb begin
      w_advance      = 1'b0;
      w_pc_stall     = 1'b0;
      w_ifid_stall   = 1'b0;
      w_ifid_flush   = 1'b0;
      w_idex_bubble  = 1'b0;
      w_idex_hold    = 1'b0;
      w_exmem_bubble = 1'b0;
      w_busy         = 1'b0;
      w_nxt_state    = r_state;
      w_nxt_cnt      = r_cnt;
      w_nxt_ex       = r_ex;
      w_nxt_mem      = r_mem;
      w_nxt_wb       = r_wb;
      w_nxt_fwd_a    = r_fwd_a;
      w_nxt_fwd_b    = r_fwd_b;

      case (r_state)
         ST_RUN: begin
            w_advance = 1'b1;
            if (hz.br_taken) begin
               // Wrong-path ID instruction is squashed; a pending
               // load-use stall is moot since that instruction is gone
               w_ifid_flush  = 1'b1;
               w_idex_bubble = 1'b1;
            end else if (w_load_use) begin
               w_pc_stall    = 1'b1;
               w_ifid_stall  = 1'b1;
               w_idex_bubble = 1'b1;
            end else begin
               w_idex_bubble = 1'b0;
            end
         end
         ST_MC_BUSY: begin
            w_busy = 1'b1;
            if (r_cnt != 4'd0) begin
               // Op still computing: freeze the front end, drain MEM
               w_pc_stall     = 1'b1;
               w_ifid_stall   = 1'b1;
               w_idex_hold    = 1'b1;
               w_exmem_bubble = 1'b1;
               w_nxt_cnt      = r_cnt - 4'd1;
               w_nxt_mem      = SB_EMPTY;
               w_nxt_wb       = r_mem;
            end else begin
               // Last EX cycle: result leaves and the pipe moves again
               w_advance = 1'b1;
            end
         end
         default: begin
            w_nxt_state = ST_RUN;
         end
      endcase

      if (w_advance) begin
         w_nxt_ex    = w_idex_bubble ? SB_EMPTY : w_id_entry;
         w_nxt_mem   = r_ex;
         w_nxt_wb    = r_mem;
         w_nxt_fwd_a = w_idex_bubble ? 2'b00 : w_fwd_a;
         w_nxt_fwd_b = w_idex_bubble ? 2'b00 : w_fwd_b;
         if (!w_idex_bubble && hz.id_valid && hz.id_multi) begin
            w_nxt_state = ST_MC_BUSY;
            w_nxt_cnt   = CNT_LOAD;
         end else begin
            w_nxt_state = ST_RUN;
            w_nxt_cnt   = 4'd0;
         end
      end else begin
         w_nxt_ex = r_ex;
      end
   end

   // State, counter, shadow scoreboard and forward-select registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_RUN;
         r_cnt   <= 4'd0;
         r_ex    <= SB_EMPTY;
         r_mem   <= SB_EMPTY;
         r_wb    <= SB_EMPTY;
         r_fwd_a <= 2'b00;
         r_fwd_b <= 2'b00;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
         r_ex    <= w_nxt_ex;
         r_mem   <= w_nxt_mem;
         r_wb    <= w_nxt_wb;
         r_fwd_a <= w_nxt_fwd_a;
         r_fwd_b <= w_nxt_fwd_b;
      end
   end

   // Controls are forced low while reset is held, whatever the inputs do
   assign hz.pc_stall     = w_pc_stall     & ~RST;
   assign hz.ifid_stall   = w_ifid_stall   & ~RST;
   assign hz.ifid_flush   = w_ifid_flush   & ~RST;
   assign hz.idex_bubble  = w_idex_bubble  & ~RST;
   assign hz.idex_hold    = w_idex_hold    & ~RST;
   assign hz.exmem_bubble = w_exmem_bubble & ~RST;
   assign hz.busy         = w_busy         & ~RST;
   assign hz.fwd_a_sel    = r_fwd_a;
   assign hz.fwd_b_sel    = r_fwd_b;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MC_LAT=4, ZERO_REG=1). Control outputs
// are compared in the cycle they are driven; forward selects are pushed to
// a scoreboard queue at issue and popped after the next clock edge.
module tb_hazard_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   hazard_ctrl_if hz ();

   hazard_ctrl #(.MC_LAT(4), .ZERO_REG(1'b1)) dut (
      .CLK (clk),
      .RST (rst),
      .hz  (hz.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [3:0] fwd;   // {fwd_a_sel, fwd_b_sel}
   } exp_t;

   exp_t sb_q[$];

   // Control vector order: pc_stall ifid_stall ifid_flush idex_bubble
   //                       idex_hold exmem_bubble busy
   localparam logic [6:0] C_NONE = 7'b0000000;
   localparam logic [6:0] C_LU   = 7'b1101000;
   localparam logic [6:0] C_BR   = 7'b0011000;
   localparam logic [6:0] C_MC   = 7'b1100111;
   localparam logic [6:0] C_MCF  = 7'b0000001;

   function automatic logic [6:0] ctrl_v();
      return {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_bubble,
              hz.idex_hold, hz.exmem_bubble, hz.busy};
   endfunction

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input logic wen, input logic ld, input logic mul,
                      input logic [3:0] rd, input logic [3:0] rs1, input logic u1,
                      input logic [3:0] rs2, input logic u2, input logic br);
      hz.id_valid      = v;
      hz.id_WRegEn     = wen;
      hz.id_mem_to_reg = ld;
      hz.id_multi      = mul;
      hz.id_WReg1      = rd;
      hz.id_rs1        = rs1;
      hz.id_rs1_used   = u1;
      hz.id_rs2        = rs2;
      hz.id_rs2_used   = u2;
      hz.br_taken      = br;
      #1;
   endtask

   task automatic drv_rand();
      drv(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
          4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
   endtask

   // Advance one clock and compare the oldest expected forward selects
   task automatic tick();
      exp_t e;
      @(posedge clk);
      @(negedge clk);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({e.tag, "_fwd"}, {3'b000, hz.fwd_a_sel, hz.fwd_b_sel}, {3'b000, e.fwd});
      end else begin
         checks++;
         failures++;
         $error("FAIL sb_empty observed=0 expected=1");
      end
   endtask

   // Check current controls, queue the expected forward result, clock
   task automatic step(input string tag, input logic [6:0] ctrl_exp, input logic [3:0] fwd_exp);
      exp_t e;
      chk({tag, "_ctrl"}, ctrl_v(), ctrl_exp);
      e.tag = tag;
      e.fwd = fwd_exp;
      sb_q.push_back(e);
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // Reset held two cycles with random inputs
      rst = 1'b1;
      drv_rand();
      sb_q.push_back('{tag: "rst1", fwd: 4'b0000});
      tick();
      chk("rst1_ctrl", ctrl_v(), C_NONE);
      drv_rand();
      sb_q.push_back('{tag: "rst2", fwd: 4'b0000});
      tick();
      chk("rst2_ctrl", ctrl_v(), C_NONE);
      rst = 1'b0;

      // Back-to-back ALU forwarding
      drv(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd7, 1'b1, 4'd8, 1'b1, 1'b0);
      step("first", C_NONE, 4'b0000);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd9, 1'b1, 4'd10, 1'b1, 1'b0);
      step("alu_nodep", C_NONE, 4'b0000);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 4'd3, 1'b1, 4'd5, 1'b1, 1'b0);
      step("ex_fwd", C_NONE, 4'b0100);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd6, 1'b1, 4'd3, 1'b1, 1'b0);
      step("mem_fwd", C_NONE, 4'b0010);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 4'd5, 1'b1, 4'd4, 1'b1, 1'b0);
      step("both_fwd", C_NONE, 4'b0110);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0);
      step("r0_dst", C_NONE, 4'b0000);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 4'd0, 1'b1, 4'd6, 1'b0, 1'b0);
      step("r0_src_unused", C_NONE, 4'b0000);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 4'd8, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0);
      step("r0_mem", C_NONE, 4'b0000);

      // Load-use: one stall cycle, then MEM forwarding on both operands
      drv(1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 4'd9, 1'b1, 4'd0, 1'b0, 1'b0);
      step("load_issue", C_NONE, 4'b0000);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 4'd2, 1'b1, 4'd2, 1'b1, 1'b0);
      step("lu_stall", C_LU, 4'b0000);
      step("lu_resume", C_NONE, 4'b1010);
      drv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      step("nop", C_NONE, 4'b0000);

      // Taken branch in the same cycle as a load-use hazard
      drv(1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0);
      step("load2", C_NONE, 4'b0000);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 4'd4, 1'b1, 4'd1, 1'b1, 1'b1);
      step("br_over_lu", C_BR, 4'b0000);

      // Multi-cycle op: 4 cycles in EX, branch pulses ignored while busy
      drv(1'b1, 1'b1, 1'b0, 1'b0, 4'd11, 4'd12, 1'b1, 4'd13, 1'b1, 1'b0);
      step("alu_pre_mul", C_NONE, 4'b0000);
      drv(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 4'd11, 1'b1, 4'd2, 1'b1, 1'b0);
      step("mul_issue", C_NONE, 4'b0100);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 4'd11, 1'b1, 4'd5, 1'b1, 1'b1);
      step("mc1", C_MC, 4'b0100);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 4'd11, 1'b1, 4'd5, 1'b1, 1'b0);
      step("mc2", C_MC, 4'b0100);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 4'd11, 1'b1, 4'd5, 1'b1, 1'b1);
      step("mc3", C_MC, 4'b0100);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 4'd11, 1'b1, 4'd5, 1'b1, 1'b0);
      step("mc_final", C_MCF, 4'b0001);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 4'd8, 4'd5, 1'b1, 4'd7, 1'b1, 1'b0);
      step("mc_resume", C_NONE, 4'b1001);

      // Reset while a multi-cycle op has two cycles left
      drv(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0);
      step("mul2_issue", C_NONE, 4'b0000);
      drv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      step("mul2_b1", C_MC, 4'b0000);
      rst = 1'b1;
      drv_rand();
      step("rst_mc", C_NONE, 4'b0000);
      rst = 1'b0;
      drv(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      step("post_rst", C_NONE, 4'b0000);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd9, 1'b1, 4'd8, 1'b1, 1'b0);
      step("post_rst_ins", C_NONE, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
